lc3x_muldiv_unit: RTL and testbench
===================================

Name: lc3x_muldiv_unit

Overview:
Iterative multiply/divide unit for the LC-3x OPS instructions (ir[5:3]=000 multiply, 001 divide) that the control word marks with mult_div=1.
- Sits beside the ALU in the EX stage.
- Computes one result bit per cycle.
- Holds the pipeline with a stall output until the result is ready.
- Presents the result for exactly one cycle so the EX/MEM latch captures it through the lc3x mux.

Parameters:
WIDTH, 16, operand and result width in bits.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  EX-stage instruction is mult/div (control word mult_div); level, held while stalled.
op  input  1  0 = multiply, 1 = divide (from lc3x_mux_sel bit 1).
flush  input  1  branch/redirect kill of the EX-stage instruction; aborts the operation.
a  input  WIDTH  SR1 value (multiplicand / dividend).
b  input  WIDTH  SR2 value (multiplier / divisor).
result  output  WIDTH  product low half, or quotient.
remainder  output  WIDTH  divide remainder; 0 for multiply.
done  output  1  one-cycle pulse; result and remainder are valid.
busy  output  1  state != IDLE.
stall  output  1  freezes the PC, IF/ID, ID/EX and EX/MEM latches.

Behaviour:
Reset (asynchronous, reset_n=0):
- State goes to IDLE.
- result, remainder, done, busy, counter and internal accumulators all go to 0.
- Reset deasserted mid-RUN: the unit restarts clean in IDLE. No partial result is visible.

States: IDLE, RUN, DONE.

IDLE:
- start=1, flush=0, b!=0 or op=0: latch a, b and op. Counter = WIDTH. Go to RUN.
- start=1, flush=0, op=1, b=0 (divide by zero): result=all-ones, remainder=a. Go straight to DONE.
- Otherwise stay in IDLE.

RUN: one iteration per cycle. Counter decrements. Go to DONE when the counter reaches 1 and that iteration completes.
- Multiply (unsigned shift-add):
  - If the multiplier LSB=1, add the multiplicand to the accumulator.
  - Shift the multiplicand left and the multiplier right.
  - Only the low WIDTH bits are kept; overflow is silently discarded. Low WIDTH bits are identical for signed two's-complement operands.
- Divide (unsigned restoring):
  - Shift {rem, quo} left one bit.
  - If rem >= divisor: subtract the divisor and set quo LSB=1.
  - rem uses WIDTH+1 bits internally.

DONE (lasts exactly one cycle):
- done=1; result and remainder are driven.
- Next state is IDLE unconditionally.
- start is ignored in DONE, because the old instruction is still on the start line this cycle.
- result and remainder hold their values in IDLE until the next operation completes.

stall = (state==IDLE && start && !flush) || state==RUN.
- stall=0 in DONE, so the pipeline advances on that edge with the result.

Latency:
- Start accepted in cycle 0; done=1 in cycle WIDTH+1 (cycle 17 for WIDTH=16).
- Divide by zero: done=1 in cycle 1.

Back-to-back: a second mult/div reaches EX in the cycle after DONE. It is seen in IDLE and starts normally, with no bubble beyond that IDLE cycle.

flush:
- In any state, flush=1 forces IDLE on the next edge.
- done is not asserted for the killed operation; result and remainder keep their previous values.
- flush has priority over start.

op, a and b are sampled only on the IDLE->RUN edge. Changes during RUN are ignored.

Test Plan:
- Multiply 7 x 6: start asserted cycle 0, op=0, a=0x0007, b=0x0006 -> stall=1 in cycles 0-16; done=1 only in cycle 17; result=0x002A, remainder=0x0000.
- Multiply overflow 0x1234 x 0x0010 -> result=0x2340. Also 0xFFFF x 0x0002 -> result=0xFFFE.
- Divide 100 / 7 (0x0064 / 0x0007) -> done in cycle 17; result=0x000E, remainder=0x0002. Also 0x0005 / 0x0009 -> result=0x0000, remainder=0x0005.
- Divide by zero: a=0x1234, b=0 -> done in cycle 1; result=0xFFFF, remainder=0x1234; stall=1 only in cycle 0.
- flush=1 in cycle 5 of a multiply -> IDLE in cycle 6; done never pulses; result unchanged. Then start in cycle 7 (7x6) -> done in cycle 24 with 0x002A.
- Back-to-back, plus reset:
  - Back-to-back: hold start through DONE, then present a new op (12 x 3) in the following IDLE cycle -> no second start during DONE; the second done carries 0x0024.
  - Reset: reset_n=0 during RUN -> busy, stall and done are 0 immediately (asynchronous) and result=0.

Source files
------------

// File: rtl/lc3x_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : lc3x_muldiv_unit
//  Purpose  : Iterative multiply/divide unit for the LC-3x OPS instructions.
//             Sits beside the ALU in EX and computes one result bit per
//             cycle: unsigned shift-add multiply (low half kept) and unsigned
//             restoring divide. While it works, it stalls the pipeline. It
//             presents the result with a single-cycle done pulse.
//  Ports    : clk        - system clock, rising edge
//             reset_n    - asynchronous active-low reset
//             start      - EX instruction is mult/div (level, held while stalled)
//             op         - 0 = multiply, 1 = divide
//             flush      - kill of the EX instruction, aborts the operation
//             a, b       - SR1 / SR2 operands
//             result     - product low half, or quotient
//             remainder  - divide remainder (0 for multiply)
//             done       - one-cycle pulse, result/remainder valid
//             busy       - unit not idle
//             stall      - freezes PC and pipeline latches
//  Revision : 1.0 - initial release
// ============================================================================
module lc3x_muldiv_unit #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic             flush,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             done,
    output logic             busy,
    output logic             stall
);

    localparam int             CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    logic             op_q,        op_d;
    // Multiply: opa = shifting multiplicand, opb = shifting multiplier,
    //           acc = running product.
    // Divide  : opb = divisor, acc = quotient register (starts as dividend),
    //           rem = partial remainder.
    logic [WIDTH-1:0] opa_q,       opa_d;
    logic [WIDTH-1:0] opb_q,       opb_d;
    logic [WIDTH-1:0] acc_q,       acc_d;
    logic [WIDTH-1:0] rem_q,       rem_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;

    // One iteration of each algorithm, evaluated every cycle.
    logic [WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]   w_div_rem_sh;
    logic             w_div_ge;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;

    always_comb begin
        w_mul_acc    = opb_q[0] ? (acc_q + opa_q) : acc_q;
        // Shift {rem, quo} left by one; the shifted remainder needs one
        // extra bit, because it can reach 2*divisor-1.
        w_div_rem_sh = {rem_q, acc_q[WIDTH-1]};
        w_div_ge     = (w_div_rem_sh >= {1'b0, opb_q});
        w_div_rem    = w_div_ge ? WIDTH'(w_div_rem_sh - {1'b0, opb_q})
                                : w_div_rem_sh[WIDTH-1:0];
        w_div_quo    = {acc_q[WIDTH-2:0], w_div_ge};
    end

    // Next-state and datapath control
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        rem_d       = rem_q;
        result_d    = result_q;
        remainder_d = remainder_q;

        if (flush) begin
            // A killed instruction never reaches DONE, so the result regs keep
            // their previous values.
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        if (op && (b == '0)) begin
                            // Divide by zero resolves immediately.
                            result_d    = '1;
                            remainder_d = a;
                            state_d     = S_DONE;
                        end else begin
                            op_d    = op;
                            opa_d   = a;
                            opb_d   = b;
                            acc_d   = op ? a : '0;
                            rem_d   = '0;
                            cnt_d   = CNT_INIT;
                            state_d = S_RUN;
                        end
                    end
                end

                S_RUN: begin
                    cnt_d = cnt_q - CNT_LAST;
                    if (op_q) begin
                        acc_d = w_div_quo;
                        rem_d = w_div_rem;
                    end else begin
                        acc_d = w_mul_acc;
                        opa_d = opa_q << 1;
                        opb_d = opb_q >> 1;
                    end
                    if (cnt_q == CNT_LAST) begin
                        result_d    = op_q ? w_div_quo : w_mul_acc;
                        remainder_d = op_q ? w_div_rem : '0;
                        state_d     = S_DONE;
                    end
                end

                S_DONE: begin
                    // The finished instruction is still on start this cycle,
                    // so start is ignored here.
                    state_d = S_IDLE;
                end

                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            rem_q       <= '0;
            result_q    <= '0;
            remainder_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            rem_q       <= rem_d;
            result_q    <= result_d;
            remainder_q <= remainder_d;
        end
    end

    assign result    = result_q;
    assign remainder = remainder_q;
    assign done      = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    // The stall drops in DONE so the pipeline advances with the result.
    assign stall     = ((state_q == S_IDLE) && start && !flush) || (state_q == S_RUN);

endmodule
`default_nettype wire

// File: tb/tb_lc3x_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lc3x_muldiv_unit
//  Purpose  : Self-checking bench for lc3x_muldiv_unit. Expected results are
//             queued when an operation is launched and compared whenever
//             done pulses. Stall profile and latency are checked per cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_lc3x_muldiv_unit;

    localparam int WIDTH = 16;

    logic             clk;
    logic             reset_n;
    logic             start;
    logic             op;
    logic             flush;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             done;
    logic             busy;
    logic             stall;

    lc3x_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .flush     (flush),
        .a         (a),
        .b         (b),
        .result    (result),
        .remainder (remainder),
        .done      (done),
        .busy      (busy),
        .stall     (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] rem;
    } exp_t;

    exp_t             sb[$];
    int               n_vec;
    int               n_err;
    logic [WIDTH-1:0] last_res;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec = n_vec + 1;
        if (obs !== exp_v) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest queued entry.
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb.size() == 0) begin
                check_eq("spurious_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("result", 32'(result), 32'(e.res));
                check_eq("remainder", 32'(remainder), 32'(e.rem));
                last_res = e.res;
            end
        end
    end

    // Launch an operation at the current cycle (cycle 0), hold start until
    // done, check the stall each cycle and the done latency. Returns #1 after
    // the edge that ends the DONE cycle, with inputs still held.
    task automatic do_op(input logic op_v, input logic [WIDTH-1:0] a_v,
                         input logic [WIDTH-1:0] b_v, input int lat);
        exp_t e;
        int   k;
        bit   got;
        if (op_v && b_v == '0) begin
            e.res = '1;
            e.rem = a_v;
        end else if (op_v) begin
            e.res = a_v / b_v;
            e.rem = a_v % b_v;
        end else begin
            e.res = WIDTH'(32'(a_v) * 32'(b_v));
            e.rem = '0;
        end
        sb.push_back(e);
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        k     = 0;
        got   = 1'b0;
        while (k < 40 && !got) begin
            @(negedge clk);
            check_eq("stall", 32'(stall), 32'(k < lat));
            if (done) begin
                check_eq("latency", 32'(k), 32'(lat));
                got = 1'b1;
            end
            @(posedge clk);
            #1;
            k = k + 1;
        end
        if (!got) check_eq("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle_cycle();
        start = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        last_res = '0;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 1'b0;
        flush    = 1'b0;
        a        = '0;
        b        = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy",  32'(busy),      32'd0);
        check_eq("rst_stall", 32'(stall),     32'd0);
        check_eq("rst_done",  32'(done),      32'd0);
        check_eq("rst_res",   32'(result),    32'd0);
        check_eq("rst_rem",   32'(remainder), 32'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed multiplies and divides
        do_op(1'b0, 16'h0007, 16'h0006, 17); idle_cycle();
        do_op(1'b0, 16'h1234, 16'h0010, 17); idle_cycle();
        do_op(1'b0, 16'hFFFF, 16'h0002, 17); idle_cycle();
        do_op(1'b1, 16'h0064, 16'h0007, 17); idle_cycle();
        do_op(1'b1, 16'h0005, 16'h0009, 17); idle_cycle();
        do_op(1'b1, 16'h1234, 16'h0000, 1);  idle_cycle();
        check_eq("hold_res", 32'(result), 32'hFFFF);

        // Flush in cycle 5 of a multiply
        start = 1'b1; op = 1'b0; a = 16'h00FF; b = 16'h0101;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
        end
        flush = 1'b1;
        @(negedge clk);
        check_eq("flush_stall", 32'(stall), 32'd1);
        @(posedge clk);
        #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_res", 32'(result), 32'(last_res));
        @(posedge clk);
        #1;
        do_op(1'b0, 16'h0007, 16'h0006, 17);

        // Back-to-back: second op presented in the IDLE cycle after DONE
        do_op(1'b0, 16'h000C, 16'h0003, 17); idle_cycle();

        // Random operands
        for (int i = 0; i < 6; i++) begin
            logic [WIDTH-1:0] ra;
            logic [WIDTH-1:0] rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom_range(1, 65535));
            do_op(1'(i % 2), ra, rb, 17);
            idle_cycle();
        end

        // Asynchronous reset during RUN
        start = 1'b1; op = 1'b0; a = 16'h0003; b = 16'h0005;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_eq("run_busy", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        start   = 1'b0;
        #1;
        check_eq("arst_busy",  32'(busy),   32'd0);
        check_eq("arst_stall", 32'(stall),  32'd0);
        check_eq("arst_done",  32'(done),   32'd0);
        check_eq("arst_res",   32'(result), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        do_op(1'b1, 16'h0064, 16'h0007, 17); idle_cycle();

        check_eq("sb_empty", 32'(sb.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
